rsa256_uart_bridge: RTL and testbench



---
 rtl/rsa256_uart_bridge_pkg.sv | 39 +++
 rtl/rsa256_uart_bridge_if.sv | 29 ++
 rtl/rsa256_uart_bridge_avm_port.sv | 44 ++++
 rtl/rsa256_uart_bridge.sv | 157 +++++++++++++++
 tb/tb_rsa256_uart_bridge.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rsa256_uart_bridge_pkg.sv
// Shared constants and types for the RSA-256 UART bridge.
// UART register map, status bit positions, FSM state and key-phase enums.
package rsa256_pkg;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;

  localparam int RX_OK_BIT = 7;
  localparam int TX_OK_BIT = 6;

  // Bytes per received operand, and bytes returned per block (top result byte is dropped)
  localparam logic [5:0] BYTES_IN  = 6'd32;
  localparam logic [5:0] BYTES_OUT = 6'd31;

  typedef enum logic [2:0] {
    S_QUERY_RX,
    S_READ,
    S_START,
    S_CALC,
    S_QUERY_TX,
    S_WRITE
  } state_t;

  typedef enum logic [1:0] {
    PH_N,
    PH_D,
    PH_A
  } phase_t;

  // N then D then ciphertext; ciphertext blocks repeat with the keys kept
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_N:    return PH_D;
      default: return PH_A;
    endcase
  endfunction

endpackage

// File: rtl/rsa256_uart_bridge_if.sv
// Avalon-MM bus between the bridge (master) and the UART peripheral (slave).
interface rsa256_uart_bridge_if;

  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    output avm_write,
    output avm_writedata,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_write,
    input  avm_writedata,
    output avm_readdata,
    output avm_waitrequest
  );

endinterface

// File: rtl/rsa256_uart_bridge_avm_port.sv
// Avalon-MM request register: holds a request stable through waitrequest,
// reports the accepting edge as a single strobe, and forces a one-cycle
// idle gap after every accepted transfer.
module rsa_avm_port
  import rsa256_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  rsa256_uart_bridge_if.master        avm,
  input  logic                        req_read,
  input  logic                        req_write,
  input  logic [4:0]                  req_address,
  input  logic [7:0]                  req_wbyte,
  output logic                        accepted,
  output logic [7:0]                  rd_byte
);

  logic busy;
  logic unused_rd_hi;

  assign busy         = avm.avm_read | avm.avm_write;
  assign accepted     = busy & ~avm.avm_waitrequest;
  assign rd_byte      = avm.avm_readdata[7:0];
  assign unused_rd_hi = ^avm.avm_readdata[31:8];

  // Request register: reset starts a status poll, accept drops the request, idle loads the next one
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      avm.avm_address   <= STATUS_BASE;
      avm.avm_read      <= 1'b1;
      avm.avm_write     <= 1'b0;
      avm.avm_writedata <= 32'd0;
    end else if (accepted) begin
      avm.avm_read  <= 1'b0;
      avm.avm_write <= 1'b0;
    end else if (!busy) begin
      avm.avm_address   <= req_address;
      avm.avm_read      <= req_read;
      avm.avm_write     <= req_write & ~req_read;
      avm.avm_writedata <= {24'd0, req_wbyte};
    end
  end

endmodule

// File: rtl/rsa256_uart_bridge.sv
// RSA-256 UART bridge: loads N, D and ciphertext blocks byte-wise from a
// polled UART, runs the decryption core per block and streams back 31
// plaintext bytes. Optional feature macro: RSA_BRIDGE_KEY_RELOAD_EN adds
// i_key_reload, which sends the bridge back to key loading after the
// current block.
module rsa256_uart_bridge
  import rsa256_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  rsa256_uart_bridge_if.master  avm,
  output logic                  o_core_start,
  output logic [255:0]          o_core_a,
  output logic [255:0]          o_core_d,
  output logic [255:0]          o_core_n,
  input  logic [255:0]          i_core_a_pow_d,
  input  logic                  i_core_finished
`ifdef RSA_BRIDGE_KEY_RELOAD_EN
  ,
  input  logic                  i_key_reload
`endif
);

  state_t         state, next_state;
  phase_t         phase;
  logic [5:0]     byte_cnt;
  logic [255:0]   n_reg, d_reg, a_reg;
  logic [247:0]   out_reg;
  logic           calc_armed;
  logic           accepted;
  logic [7:0]     rd_byte;
  logic           req_read, req_write;
  logic [4:0]     req_address;
  logic           rx_take, tx_done, last_in, last_out, finish_seen, reload_now;
  logic           unused_result_hi;

  assign rx_take          = (state == S_READ)  && accepted;
  assign tx_done          = (state == S_WRITE) && accepted;
  assign last_in          = (byte_cnt == BYTES_IN - 6'd1);
  assign last_out         = (byte_cnt == BYTES_OUT - 6'd1);
  assign finish_seen      = (state == S_CALC) && calc_armed && i_core_finished;
  assign unused_result_hi = ^i_core_a_pow_d[255:248];

  assign o_core_n = n_reg;
  assign o_core_d = d_reg;
  assign o_core_a = a_reg;

  rsa_avm_port u_port (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .avm         (avm),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_address (req_address),
    .req_wbyte   (out_reg[247:240]),
    .accepted    (accepted),
    .rd_byte     (rd_byte)
  );

  // State register; calc_armed masks a finished flag left over from the previous block
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_QUERY_RX;
      calc_armed <= 1'b0;
    end else begin
      state      <= next_state;
      calc_armed <= (state == S_CALC);
    end
  end

  // Next-state decode driven by the port's accept strobe and the byte counter
  always_comb begin
    next_state = state;
    unique case (state)
      S_QUERY_RX: if (accepted && rd_byte[RX_OK_BIT]) next_state = S_READ;
      S_READ:     if (accepted) next_state = (last_in && phase == PH_A) ? S_START : S_QUERY_RX;
      S_START:    next_state = S_CALC;
      S_CALC:     if (finish_seen) next_state = S_QUERY_TX;
      S_QUERY_TX: if (accepted && rd_byte[TX_OK_BIT]) next_state = S_WRITE;
      S_WRITE:    if (accepted) next_state = last_out ? S_QUERY_RX : S_QUERY_TX;
      default:    next_state = S_QUERY_RX;
    endcase
  end

  // Outputs; bus requests follow next_state so the port can issue them right after the gap
  always_comb begin
    o_core_start = (state == S_START);
    req_read     = 1'b0;
    req_write    = 1'b0;
    req_address  = STATUS_BASE;
    unique case (next_state)
      S_QUERY_RX, S_QUERY_TX: req_read = 1'b1;
      S_READ: begin
        req_read    = 1'b1;
        req_address = RX_BASE;
      end
      S_WRITE: begin
        req_write   = 1'b1;
        req_address = TX_BASE;
      end
      default: ;
    endcase
  end

  // Operand assembly, result capture/shift-out, byte counter and key phase
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      phase    <= PH_N;
      byte_cnt <= 6'd0;
      n_reg    <= '0;
      d_reg    <= '0;
      a_reg    <= '0;
      out_reg  <= '0;
    end else begin
      if (rx_take) begin
        case (phase)
          PH_N:    n_reg <= {n_reg[247:0], rd_byte};
          PH_D:    d_reg <= {d_reg[247:0], rd_byte};
          default: a_reg <= {a_reg[247:0], rd_byte};
        endcase
        if (last_in) begin
          byte_cnt <= 6'd0;
          phase    <= next_phase(phase);
        end else begin
          byte_cnt <= byte_cnt + 6'd1;
        end
      end
      if (finish_seen) out_reg <= i_core_a_pow_d[247:0];
      if (tx_done) begin
        out_reg  <= {out_reg[239:0], 8'h00};
        byte_cnt <= last_out ? 6'd0 : byte_cnt + 6'd1;
      end
      if (reload_now) begin
        phase    <= PH_N;
        byte_cnt <= 6'd0;
      end
    end
  end

`ifdef RSA_BRIDGE_KEY_RELOAD_EN
  logic reload_flag;

  assign reload_now = (reload_flag | i_key_reload) &
                      ((tx_done & last_out) |
                       (phase == PH_A && state == S_QUERY_RX && byte_cnt == 6'd0));

  // Sticky reload request, consumed once the bridge sits between blocks
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)          reload_flag <= 1'b0;
    else if (reload_now)   reload_flag <= 1'b0;
    else if (i_key_reload) reload_flag <= 1'b1;
  end
`else
  assign reload_now = 1'b0;
`endif

endmodule

// File: tb/tb_rsa256_uart_bridge.sv
// Testbench for rsa256_uart_bridge: UART slave model, stub RSA core and a
// byte scoreboard. Also exercises RSA_BRIDGE_KEY_RELOAD_EN when defined.
module tb_rsa256_uart_bridge;

  typedef struct {
    int          waits;
    int          rx_stall;
    int          tx_stall;
    bit          drain;
    logic [255:0] cipher;
    logic [255:0] result;
    logic [247:0] exp_out;
  } vec_t;

  typedef struct {
    logic [255:0] a;
    logic [255:0] result;
  } blk_t;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         o_core_start;
  logic [255:0] o_core_a, o_core_d, o_core_n;
  logic [255:0] i_core_a_pow_d = '0;
  logic         i_core_finished = 1'b0;
`ifdef RSA_BRIDGE_KEY_RELOAD_EN
  logic         i_key_reload = 1'b0;
`endif

  rsa256_uart_bridge_if avm ();

  rsa256_uart_bridge dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .avm             (avm),
    .o_core_start    (o_core_start),
    .o_core_a        (o_core_a),
    .o_core_d        (o_core_d),
    .o_core_n        (o_core_n),
    .i_core_a_pow_d  (i_core_a_pow_d),
    .i_core_finished (i_core_finished)
`ifdef RSA_BRIDGE_KEY_RELOAD_EN
    ,
    .i_key_reload    (i_key_reload)
`endif
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  byte unsigned rx_q[$];
  byte unsigned exp_q[$];
  blk_t         core_q[$];
  logic [255:0] exp_n = '0;
  logic [255:0] exp_d = '0;
  int wait_cfg = 0, rx_stall = 0, tx_stall_cfg = 0, tx_stall = 0;
  int rx_reads = 0, rx_pushed = 0, writes = 0, starts = 0;
  bit rx_granted = 1'b0, tx_granted = 1'b0;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pushBytes(input logic [255:0] v, input int count);
    for (int b = 31; b > 31 - count; b--) rx_q.push_back(v[b*8 +: 8]);
    rx_pushed += count;
  endtask

  task automatic applyStimulus(input vec_t v);
    blk_t blk;
    wait_cfg     = v.waits;
    tx_stall_cfg = v.tx_stall;
    rx_stall    += v.rx_stall;
    pushBytes(v.cipher, 32);
    blk.a      = v.cipher;
    blk.result = v.result;
    core_q.push_back(blk);
    for (int b = 30; b >= 0; b--) exp_q.push_back(v.exp_out[b*8 +: 8]);
  endtask

  task automatic waitDrain(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || core_q.size() != 0 || rx_q.size() != 0) && cyc < 8000) begin
      @(posedge i_clk);
      cyc++;
    end
    checkOutput({name, "_timeout"}, cyc < 8000, 1'b1);
    repeat (20) @(posedge i_clk);
    checkOutput({name, "_rx_consumed"}, rx_reads, rx_pushed);
    checkOutput({name, "_write_count"}, writes, starts * 31);
  endtask

  // UART slave: decides waitrequest/readdata at each falling edge
  initial begin : slave_model
    bit          busy;
    int          waited;
    logic [38:0] held;
    logic [31:0] rd;
    logic        avail, txok;
    busy = 1'b0;
    waited = 0;
    held = '0;
    avm.avm_waitrequest = 1'b0;
    avm.avm_readdata = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n || !(avm.avm_read || avm.avm_write)) begin
        busy = 1'b0;
        avm.avm_waitrequest = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          waited = 0;
          held = {avm.avm_address, avm.avm_read, avm.avm_write, avm.avm_writedata};
        end else begin
          checkOutput("avm_hold", {avm.avm_address, avm.avm_read, avm.avm_write, avm.avm_writedata}, held);
        end
        checkOutput("rd_wr_exclusive", avm.avm_read & avm.avm_write, 1'b0);
        if (waited < wait_cfg) begin
          waited++;
          avm.avm_waitrequest = 1'b1;
        end else begin
          avm.avm_waitrequest = 1'b0;
          busy = 1'b0;
          if (avm.avm_read && avm.avm_address == 5'd8) begin
            avail = (rx_q.size() > 0) && (rx_stall == 0);
            if (rx_q.size() > 0 && rx_stall > 0) rx_stall--;
            txok = (tx_stall == 0);
            if (tx_stall > 0) tx_stall--;
            rx_granted = avail;
            tx_granted = txok;
            rd = {24'h5A5A5A, 8'h15};
            rd[7] = avail;
            rd[6] = txok;
            avm.avm_readdata = rd;
          end else if (avm.avm_read && avm.avm_address == 5'd0) begin
            checkOutput("rx_read_granted", rx_granted, 1'b1);
            rx_granted = 1'b0;
            if (rx_q.size() > 0) begin
              rx_reads++;
              avm.avm_readdata = {24'hC3C3C3, rx_q.pop_front()};
            end else begin
              checks++;
              errors++;
              $display("[TB] FAIL rx_read_empty: got read of RX_BASE, expected no read");
              avm.avm_readdata = '0;
            end
          end else if (avm.avm_write && avm.avm_address == 5'd4) begin
            checkOutput("tx_write_granted", tx_granted, 1'b1);
            tx_granted = 1'b0;
            tx_stall = tx_stall_cfg;
            writes++;
            checkOutput("wdata_upper", avm.avm_writedata[31:8], 24'd0);
            if (exp_q.size() > 0) begin
              checkOutput("tx_byte", avm.avm_writedata[7:0], exp_q.pop_front());
            end else begin
              checks++;
              errors++;
              $display("[TB] FAIL tx_unexpected: got write %0h, expected none", avm.avm_writedata);
            end
          end else begin
            checks++;
            errors++;
            $display("[TB] FAIL bus_access: got addr %0d rd %0b wr %0b, expected valid access",
                     avm.avm_address, avm.avm_read, avm.avm_write);
          end
        end
      end
    end
  end

  // Stub core: checks operands on start, leaves the old finished flag up one extra cycle, answers later
  initial begin : core_model
    blk_t cur;
    bit   active;
    int   t, hi;
    active = 1'b0;
    t = 0;
    hi = 0;
    cur.a = '0;
    cur.result = '0;
    forever begin
      @(negedge i_clk);
      if (active) begin
        t++;
        checkOutput("core_a_stable", o_core_a, cur.a);
        if (t == 2) begin
          i_core_finished = 1'b0;
          i_core_a_pow_d = ~cur.result;
        end
        if (t == 5) begin
          i_core_a_pow_d = cur.result;
          i_core_finished = 1'b1;
          active = 1'b0;
        end
      end
      if (o_core_start) begin
        hi++;
        if (hi == 1) begin
          checkOutput("start_after_writes", writes, starts * 31);
          starts++;
          checkOutput("core_n", o_core_n, exp_n);
          checkOutput("core_d", o_core_d, exp_d);
          if (core_q.size() > 0) begin
            cur = core_q.pop_front();
            checkOutput("core_a", o_core_a, cur.a);
            active = 1'b1;
            t = 0;
          end else begin
            checks++;
            errors++;
            $display("[TB] FAIL core_start: got start, expected none");
          end
        end
      end else begin
        if (hi > 0) checkOutput("start_width", hi, 1);
        hi = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish within budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main_seq
    vec_t         vecs[3];
    logic [247:0] pat;
    logic [255:0] key_n, key_d, key_n2, key_d2;
    int           cyc, target;

    key_n  = 256'hCA3586E7EA485F3B0A222A4C79F7DD12E85388ECCDEE4035940D774C029CF831;
    key_d  = 256'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0_1357_9BDF_2468_ACE0_0F0F_F0F0_5A5A_A5A5;
    key_n2 = ~key_n;
    key_d2 = {key_d[127:0], key_d[255:128]};
    for (int b = 0; b < 31; b++) pat[b*8 +: 8] = 8'(b * 37 + 5);

    vecs[0] = '{waits: 0, rx_stall: 0, tx_stall: 0, drain: 1'b0,
                cipher: 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0,
                result: {8'h00, {31{8'h41}}}, exp_out: {31{8'h41}}};
    vecs[1] = '{waits: 0, rx_stall: 2, tx_stall: 1, drain: 1'b1,
                cipher: 256'hDEADBEEF_0BADF00D_CAFEBABE_8BADF00D_FEEDFACE_C0FFEE00_12345678_9ABCDEF0,
                result: {8'hFF, pat}, exp_out: pat};
    vecs[2] = '{waits: 3, rx_stall: 1, tx_stall: 2, drain: 1'b1,
                cipher: 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0,
                result: {8'h00, {31{8'h41}}}, exp_out: {31{8'h41}}};

    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("rst_address", avm.avm_address, 5'd8);
    checkOutput("rst_read", avm.avm_read, 1'b1);
    checkOutput("rst_write", avm.avm_write, 1'b0);
    checkOutput("rst_writedata", avm.avm_writedata, 32'd0);
    checkOutput("rst_start", o_core_start, 1'b0);
    checkOutput("rst_core_a", o_core_a, 256'd0);
    checkOutput("rst_core_d", o_core_d, 256'd0);
    checkOutput("rst_core_n", o_core_n, 256'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    exp_n = key_n;
    exp_d = key_d;
    rx_stall = 5;
    pushBytes(key_n, 32);
    pushBytes(key_d, 32);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vecs[i]);
      if (vecs[i].drain) waitDrain("block");
    end

    // Reset in the middle of D loading, then full reload
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    pushBytes(key_n2, 32);
    pushBytes(key_d2, 10);
    target = rx_pushed;
    cyc = 0;
    while (rx_reads < target && cyc < 4000) begin
      @(posedge i_clk);
      cyc++;
    end
    checkOutput("partial_load_timeout", cyc < 4000, 1'b1);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    checkOutput("midrst_read", avm.avm_read, 1'b1);
    checkOutput("midrst_address", avm.avm_address, 5'd8);
    checkOutput("midrst_write", avm.avm_write, 1'b0);
    checkOutput("midrst_core_n", o_core_n, 256'd0);
    checkOutput("midrst_core_d", o_core_d, 256'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_n = key_n;
    exp_d = key_d;
    pushBytes(key_n, 32);
    pushBytes(key_d, 32);
    applyStimulus(vecs[0]);
    waitDrain("after_reset");

`ifdef RSA_BRIDGE_KEY_RELOAD_EN
    // Reload requested while the core is busy takes effect after the block's last byte
    applyStimulus(vecs[1]);
    cyc = 0;
    while (!o_core_start && cyc < 8000) begin
      @(negedge i_clk);
      cyc++;
    end
    checkOutput("reload_start_timeout", cyc < 8000, 1'b1);
    @(negedge i_clk);
    i_key_reload = 1'b1;
    @(negedge i_clk);
    i_key_reload = 1'b0;
    waitDrain("reload_block");
    exp_n = key_n2;
    exp_d = key_d2;
    pushBytes(key_n2, 32);
    pushBytes(key_d2, 32);
    applyStimulus(vecs[0]);
    waitDrain("reloaded_keys");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
